// File: rtl/mig_arb_pkg.sv
// Shared types and MIG command encodings for the two-requester DDR3 read arbiter.
package mig_arb_pkg;

    localparam logic [2:0] APP_CMD_READ  = 3'b001;
    localparam logic [2:0] APP_CMD_WRITE = 3'b000;

    typedef enum logic {
        ARB_IDLE,
        ARB_ISSUE
    } arb_state_t;

    // Owner of a read command: 0 = embedding fetch, 1 = weight fetch.
    typedef logic req_id_t;

endpackage

// File: rtl/mig_rd_arbiter_tag_fifo.sv
// In-order FIFO of read-command owner IDs; the head names the owner of the
// next returning burst. DEPTH must be a power of two (pointers wrap naturally).
module tag_fifo
    import mig_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  req_id_t                  push_id,
    input  logic                     pop,
    output req_id_t                  head_id,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    req_id_t        r_mem [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [PW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;
    assign full    = (r_count == (PW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign head_id = r_mem[r_rptr];
    assign count   = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mig_rd_arbiter.sv
// Round-robin read arbiter for the MIG app command port with tag-steered returns.
// Optional grant statistics counters: define MIG_RD_ARB_STATS_EN.
module mig_rd_arbiter
    import mig_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         req0_valid,
    input  logic [ADDR_WIDTH-1:0]        req0_addr,
    output logic                         req0_ready,
    input  logic                         req1_valid,
    input  logic [ADDR_WIDTH-1:0]        req1_addr,
    output logic                         req1_ready,
    output logic [ADDR_WIDTH-1:0]        app_addr,
    output logic [2:0]                   app_cmd,
    output logic                         app_en,
    input  logic                         app_rdy,
    input  logic [DATA_WIDTH-1:0]        app_rd_data,
    input  logic                         app_rd_data_valid,
    input  logic                         app_rd_data_end,
    output logic                         rsp0_valid,
    output logic                         rsp1_valid,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         rsp_last,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic                         orphan_error,
    output logic [15:0]                  grant_count0,
    output logic [15:0]                  grant_count1
);

    arb_state_t               r_state;
    logic [ADDR_WIDTH-1:0]    r_addr;
    req_id_t                  r_owner;
    req_id_t                  r_last_grant;
    logic                     r_app_en;
    logic                     r_rsp0_valid;
    logic                     r_rsp1_valid;
    logic [DATA_WIDTH-1:0]    r_rsp_data;
    logic                     r_rsp_last;
    logic                     r_orphan;

    logic                     w_accept;
    logic                     w_any_req;
    req_id_t                  w_pick;
    logic                     w_full;
    logic                     w_empty;
    req_id_t                  w_head;
    logic                     w_beat_ok;
    logic                     w_pop;

    assign w_accept  = r_app_en && app_rdy;
    assign w_any_req = req0_valid || req1_valid;
    // With both requesting, the one not granted last wins; otherwise the lone requester.
    assign w_pick    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign w_beat_ok = app_rd_data_valid && !w_empty;
    assign w_pop     = w_beat_ok && app_rd_data_end;

    tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_accept),
        .push_id (r_owner),
        .pop     (w_pop),
        .head_id (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (outstanding)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB_IDLE;
            r_addr       <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_app_en     <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (enable && w_any_req && !w_full) begin
                        r_owner  <= w_pick;
                        r_addr   <= w_pick ? req1_addr : req0_addr;
                        r_app_en <= 1'b1;
                        r_state  <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (app_rdy) begin
                        r_last_grant <= r_owner;
                        r_app_en     <= 1'b0;
                        r_state      <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_last   <= 1'b0;
            r_orphan     <= 1'b0;
        end else begin
            r_rsp0_valid <= w_beat_ok && (w_head == 1'b0);
            r_rsp1_valid <= w_beat_ok && (w_head == 1'b1);
            r_rsp_data   <= app_rd_data;
            r_rsp_last   <= w_beat_ok && app_rd_data_end;
            r_orphan     <= r_orphan || (app_rd_data_valid && w_empty);
        end
    end

    assign app_en       = r_app_en;
    assign app_addr     = r_addr;
    assign app_cmd      = APP_CMD_READ;
    assign req0_ready   = w_accept && (r_owner == 1'b0);
    assign req1_ready   = w_accept && (r_owner == 1'b1);
    assign rsp0_valid   = r_rsp0_valid;
    assign rsp1_valid   = r_rsp1_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_last     = r_rsp_last;
    assign orphan_error = r_orphan;

`ifdef MIG_RD_ARB_STATS_EN
    logic [15:0] r_grant_count0;
    logic [15:0] r_grant_count1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_count0 <= '0;
            r_grant_count1 <= '0;
        end else begin
            if (req0_ready && (r_grant_count0 != '1)) begin
                r_grant_count0 <= r_grant_count0 + 1'b1;
            end
            if (req1_ready && (r_grant_count1 != '1)) begin
                r_grant_count1 <= r_grant_count1 + 1'b1;
            end
        end
    end

    assign grant_count0 = r_grant_count0;
    assign grant_count1 = r_grant_count1;
`else
    assign grant_count0 = '0;
    assign grant_count1 = '0;
`endif

endmodule

// File: tb/tb_mig_rd_arbiter.sv
// Bench for mig_rd_arbiter: directed scenarios then random traffic against a
// transaction-level model (owner queue, round-robin pointer, pending command).
module tb_mig_rd_arbiter;

    localparam int AW = 27;
    localparam int DW = 64;
    localparam int TD = 8;
    localparam int OW = $clog2(TD) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          app_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid, app_rd_data_end;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic [OW-1:0] outstanding;
    logic          orphan_error;
    logic [15:0]   grant_count0, grant_count1;

    mig_rd_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TAG_DEPTH  (TD)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .req0_valid        (req0_valid),
        .req0_addr         (req0_addr),
        .req0_ready        (req0_ready),
        .req1_valid        (req1_valid),
        .req1_addr         (req1_addr),
        .req1_ready        (req1_ready),
        .app_addr          (app_addr),
        .app_cmd           (app_cmd),
        .app_en            (app_en),
        .app_rdy           (app_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .app_rd_data_end   (app_rd_data_end),
        .rsp0_valid        (rsp0_valid),
        .rsp1_valid        (rsp1_valid),
        .rsp_data          (rsp_data),
        .rsp_last          (rsp_last),
        .outstanding       (outstanding),
        .orphan_error      (orphan_error),
        .grant_count0      (grant_count0),
        .grant_count1      (grant_count1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state
    bit            m_pend;
    bit            m_own;
    logic [AW-1:0] m_addr;
    bit            m_last;
    int            m_q[$];
    bit            m_orph;
    bit            m_rv0, m_rv1, m_rlast;
    logic [DW-1:0] m_rdata;
    int            m_gc0, m_gc1;

    // Bench-side bookkeeping
    bit acc0, acc1;
    int cnt_rsp0, cnt_rsp1, cnt_last;
    int grants[$];
    int mig_cmds;
    bit mig_second;
    int req_pct = 50, rdy_pct = 60, ret_pct = 50;

    task automatic model_reset();
        m_pend = 0; m_own = 0; m_addr = '0; m_last = 1; m_q.delete();
        m_orph = 0; m_rv0 = 0; m_rv1 = 0; m_rlast = 0; m_rdata = '0;
        m_gc0 = 0; m_gc1 = 0;
    endtask

    task automatic check_outputs();
        bit exp_r0, exp_r1;
        exp_r0 = m_pend && app_rdy && (m_own == 0);
        exp_r1 = m_pend && app_rdy && (m_own == 1);
        check("app_en", app_en, m_pend);
        check("app_cmd", app_cmd, 3'b001);
        if (m_pend) check("app_addr", app_addr, m_addr);
        check("req0_ready", req0_ready, exp_r0);
        check("req1_ready", req1_ready, exp_r1);
        check("rsp0_valid", rsp0_valid, m_rv0);
        check("rsp1_valid", rsp1_valid, m_rv1);
        if (m_rv0 || m_rv1) begin
            check("rsp_data", rsp_data, m_rdata);
            check("rsp_last", rsp_last, m_rlast);
        end
        check("outstanding", outstanding, m_q.size());
        check("orphan_error", orphan_error, m_orph);
`ifdef MIG_RD_ARB_STATS_EN
        check("grant_count0", grant_count0, m_gc0);
        check("grant_count1", grant_count1, m_gc1);
`else
        check("grant_count0", grant_count0, 0);
        check("grant_count1", grant_count1, 0);
`endif
        acc0 = req0_ready;
        acc1 = req1_ready;
        if (req0_ready) grants.push_back(0);
        if (req1_ready) grants.push_back(1);
        if (req0_ready || req1_ready) mig_cmds++;
        if (rsp0_valid) cnt_rsp0++;
        if (rsp1_valid) cnt_rsp1++;
        if ((rsp0_valid || rsp1_valid) && rsp_last) cnt_last++;
    endtask

    task automatic model_step();
        bit full_now;
        bit nrv0, nrv1;
        full_now = (m_q.size() == TD);
        nrv0 = 0;
        nrv1 = 0;
        if (app_rd_data_valid) begin
            if (m_q.size() == 0) begin
                m_orph = 1;
            end else begin
                nrv0    = (m_q[0] == 0);
                nrv1    = (m_q[0] == 1);
                m_rdata = app_rd_data;
                m_rlast = app_rd_data_end;
                if (app_rd_data_end) void'(m_q.pop_front());
            end
        end
        if (m_pend) begin
            if (app_rdy) begin
                m_q.push_back(int'(m_own));
                m_last = m_own;
                if (m_own == 0 && m_gc0 < 65535) m_gc0++;
                if (m_own == 1 && m_gc1 < 65535) m_gc1++;
                m_pend = 0;
            end
        end else if (enable && (req0_valid || req1_valid) && !full_now) begin
            m_own  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            m_addr = m_own ? req1_addr : req0_addr;
            m_pend = 1;
        end
        m_rv0 = nrv0;
        m_rv1 = nrv1;
    endtask

    task automatic drive_auto();
        if (acc0 || !req0_valid) begin
            req0_valid = ($urandom_range(0, 99) < req_pct);
            req0_addr  = AW'($urandom);
        end
        if (acc1 || !req1_valid) begin
            req1_valid = ($urandom_range(0, 99) < req_pct);
            req1_addr  = AW'($urandom);
        end
        enable            = ($urandom_range(0, 99) < 95);
        app_rdy           = ($urandom_range(0, 99) < rdy_pct);
        app_rd_data       = {$urandom, $urandom};
        app_rd_data_end   = 1'($urandom);
        app_rd_data_valid = 1'b0;
        if ((mig_second || mig_cmds > 0) && $urandom_range(0, 99) < ret_pct) begin
            app_rd_data_valid = 1'b1;
            if (!mig_second) begin
                app_rd_data_end = 1'b0;
                mig_second      = 1;
                mig_cmds--;
            end else begin
                app_rd_data_end = 1'b1;
                mig_second      = 0;
            end
        end
    endtask

    task automatic cycle(input bit auto_drive);
        if (auto_drive) drive_auto();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit clear_mig);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        acc0 = 0;
        acc1 = 0;
        if (clear_mig) begin
            mig_cmds   = 0;
            mig_second = 0;
        end
    endtask

    task automatic set_beat(input bit v, input bit e, input logic [DW-1:0] d);
        app_rd_data_valid = v;
        app_rd_data_end   = e;
        app_rd_data       = d;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; req0_valid = 0; req1_valid = 0;
        req0_addr = '0; req1_addr = '0; app_rdy = 0;
        set_beat(0, 0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset(1);

        check("rst_app_en", app_en, 0);
        check("rst_app_cmd", app_cmd, 3'b001);
        check("rst_app_addr", app_addr, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_last", rsp_last, 0);
        check("rst_outstanding", outstanding, 0);

        // Single req0 read with two-beat return
        enable = 1; app_rdy = 1; req0_valid = 1; req0_addr = 27'h000100;
        cnt_rsp0 = 0; cnt_last = 0;
        cycle(0);
        check("t1_app_en", app_en, 1);
        check("t1_app_addr", app_addr, 27'h000100);
        cycle(0);
        req0_valid = 0;
        cycle(0);
        set_beat(1, 0, 64'h1111_2222_3333_4444);
        cycle(0);
        set_beat(1, 1, 64'h5555_6666_7777_8888);
        cycle(0);
        set_beat(0, 0, '0);
        repeat (2) cycle(0);
        check("t1_rsp0_beats", cnt_rsp0, 2);
        check("t1_last_beats", cnt_last, 1);

        // Both requesters held: alternating grants
        do_reset(1);
        grants.delete();
        req0_valid = 1; req0_addr = 27'h0000AA;
        req1_valid = 1; req1_addr = 27'h0000BB;
        repeat (8) cycle(0);
        req0_valid = 0; req1_valid = 0;
        check("rr_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) check("rr_order", grants[i], i % 2);
        check("rr_outstanding", outstanding, 4);

        // app_rdy held low during ISSUE
        app_rdy = 0; req0_valid = 1; req0_addr = 27'h012345;
        cycle(0);
        for (int i = 0; i < 5; i++) begin
            check("stall_addr", app_addr, 27'h012345);
            cycle(0);
        end
        app_rdy = 1;
        cycle(0);
        req0_valid = 0;
        check("stall_outstanding", outstanding, 5);

        // Fill the tag FIFO, then free one slot
        req0_valid = 1; req0_addr = 27'h000200;
        req1_valid = 1; req1_addr = 27'h000300;
        repeat (10) cycle(0);
        check("full_outstanding", outstanding, TD);
        check("full_no_grant", app_en, 0);
        set_beat(1, 0, 64'hA5A5);
        cycle(0);
        set_beat(1, 1, 64'h5A5A);
        cycle(0);
        set_beat(0, 0, '0);
        check("full_still_idle", app_en, 0);
        cycle(0);
        check("full_regrant", app_en, 1);
        repeat (2) cycle(0);
        req0_valid = 0; req1_valid = 0;

        // Orphan beat with the FIFO empty
        do_reset(1);
        set_beat(1, 1, 64'hDEAD);
        cycle(0);
        set_beat(0, 0, '0);
        cycle(0);
        check("orphan_set", orphan_error, 1);
        repeat (3) cycle(0);
        check("orphan_sticky", orphan_error, 1);
        do_reset(1);
        check("orphan_cleared", orphan_error, 0);

        // Three req1 grants for the statistics counters
        req1_valid = 1; req1_addr = 27'h000777;
        repeat (6) cycle(0);
        req1_valid = 0;
        cycle(0);
`ifdef MIG_RD_ARB_STATS_EN
        check("stats_gc1", grant_count1, 3);
        check("stats_gc0", grant_count0, 0);
`else
        check("stats_gc1_off", grant_count1, 0);
`endif

        // Random traffic with occasional mid-operation resets
        do_reset(1);
        for (int i = 0; i < 4000; i++) begin
            if (i % 1000 == 999) begin
                req_pct = $urandom_range(20, 90);
                rdy_pct = $urandom_range(20, 100);
                ret_pct = $urandom_range(10, 90);
            end
            if ($urandom_range(0, 699) == 0) do_reset(0);
            else cycle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
